baud_gen_param: RTL
===================

BAUD_GEN_PARAM -- requirements
Module: baud_gen_param

Interface
REQ-001 SHALL have parameter DIV_W, default 16, width of the divisor and the cycle counter (8..24).
REQ-002 SHALL have parameter OSR, default 16, rx ticks per bit period (power of two, 2..64).
REQ-003 SHALL have parameter RESET_DIV, default 325, divisor value loaded at reset (must fit in DIV_W).
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port data  input  8  divisor byte for writes.
REQ-007 SHALL have port sel_low  input  1  write data to staging divisor bits [7:0].
REQ-008 SHALL have port sel_high  input  1  write data to staging bits [DIV_W-1:8] (upper bits beyond DIV_W dropped), then arm commit.
REQ-009 SHALL have port enable  input  1  run generator when high.
REQ-010 SHALL have port rx_tick  output  1  one-cycle pulse, OSR per bit period.
REQ-011 SHALL have port tx_tick  output  1  one-cycle pulse, once per bit period.
REQ-012 SHALL have port div_pending  output  1  staged divisor awaiting commit.

Function
REQ-013 SHALL hold staging divisor stg_div and active divisor act_div, both DIV_W bits.
REQ-014 SHALL, on sel_low and sel_high both high in one cycle, perform only the sel_low write.
REQ-015 SHALL set div_pending on the cycle after a sel_high write; a sel_low write alone does not set it.
REQ-016 SHALL have a two-state FSM: IDLE, RUN.
REQ-017 SHALL in IDLE: cnt <= act_div; os_cnt <= 0; rx_tick = tx_tick = 0; if div_pending, act_div <= stg_div and div_pending clears same cycle; go to RUN when enable = 1.
REQ-018 SHALL in RUN: decrement cnt each cycle while cnt != 0.
REQ-019 SHALL in RUN with cnt == 0: pulse rx_tick (registered, visible the following cycle), reload cnt from act_div, or from stg_div (clearing div_pending) if div_pending.
REQ-020 SHALL give rx_tick period act_div+1 cycles; act_div = 0 gives rx_tick every cycle.
REQ-021 SHALL increment os_cnt (log2(OSR) bits, wraps) on each rx_tick; tx_tick pulses with the rx_tick at which os_cnt was OSR-1.
REQ-022 SHALL make first rx_tick after IDLE->RUN appear exactly act_div+2 cycles after the cycle enable is sampled high.
REQ-023 SHALL, on enable low in RUN, return to IDLE next cycle; ticks already scheduled for that cycle are suppressed; os_cnt cleared.
REQ-024 SHALL apply a commit only at reload points (REQ-017, REQ-019); divisor changes never truncate a period in progress.
REQ-025 SHALL, if sel_high and a reload coincide, commit the previous stg_div and leave div_pending set for the new value.
REQ-026 SHALL never assert tx_tick without rx_tick in the same cycle.

Reset
REQ-027 SHALL on rst: state = IDLE, stg_div = act_div = RESET_DIV, cnt = RESET_DIV, os_cnt = 0, rx_tick = tx_tick = div_pending = 0.
REQ-028 SHALL, on rst asserted mid-RUN, clear outputs immediately and ignore enable until rst deasserts; stg_div writes in progress are lost.

Verification
REQ-029 SHALL cover: reset, enable=1 held, DIV_W=16 OSR=16 RESET_DIV=3 -> rx_tick every 4 cycles, tx_tick every 64 cycles, first rx_tick 5 cycles after enable.
REQ-030 SHALL cover: in RUN write low=0x09, high=0x00 -> div_pending=1 until next reload; following periods exactly 10 cycles; period in progress unchanged.
REQ-031 SHALL cover: sel_low and sel_high both high with data=0xAA -> stg_div[7:0]=0xAA, upper byte unchanged, div_pending stays 0.
REQ-032 SHALL cover: divisor 0, OSR=16 -> rx_tick constant high, tx_tick every 16 cycles.
REQ-033 SHALL cover: enable dropped with cnt=2 then re-raised after 5 cycles -> no ticks while low; os_cnt restarts, first tx_tick after 16 full periods.
REQ-034 SHALL cover: rst pulsed mid-period with pending divisor -> outputs 0 asynchronously, act_div=RESET_DIV, div_pending=0 after release.

Source files
------------

// File: rtl/baud_gen_param.sv
// Baud-rate generator with a runtime-programmable divisor.
// rx_tick fires every act_div+1 cycles while running; tx_tick fires on every
// OSR-th rx_tick. New divisors are staged through a byte-wide write port and
// only take effect at a period boundary, so a period in progress is never cut short.
module baud_gen_param #(
  parameter int DIV_W     = 16,
  parameter int OSR       = 16,
  parameter int RESET_DIV = 325
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       sel_low,
  input  logic       sel_high,
  input  logic       enable,
  output logic       rx_tick,
  output logic       tx_tick,
  output logic       div_pending
);

  localparam int OS_W = (OSR > 1) ? $clog2(OSR) : 1;
  localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(RESET_DIV);
  localparam logic [OS_W-1:0]  OS_LAST = OS_W'(OSR - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] stg_div_q, stg_div_d;
  logic [DIV_W-1:0] act_div_q, act_div_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [OS_W-1:0]  os_cnt_q, os_cnt_d;
  logic             rx_tick_q, rx_tick_d;
  logic             tx_tick_q, tx_tick_d;
  logic             div_pending_q, div_pending_d;
  logic             wr_low, wr_high;
  logic             commit;

  // Replace bits [7:0] of the staged divisor with the data byte.
  function automatic logic [DIV_W-1:0] write_low(input logic [DIV_W-1:0] cur,
                                                 input logic [7:0]       d);
    return (cur & ~DIV_W'(8'hFF)) | DIV_W'(d);
  endfunction

  // Replace bits [DIV_W-1:8] with the zero-extended data byte; bits that do
  // not fit in DIV_W fall off the top of the shift.
  function automatic logic [DIV_W-1:0] write_high(input logic [DIV_W-1:0] cur,
                                                  input logic [7:0]       d);
    return (cur & DIV_W'(8'hFF)) | (DIV_W'(d) << 8);
  endfunction

  // Staging register writes; a simultaneous low+high strobe is treated as low only.
  always_comb begin
    wr_low    = sel_low;
    wr_high   = sel_high & ~sel_low;
    stg_div_d = stg_div_q;
    if (wr_low) begin
      stg_div_d = write_low(stg_div_q, data);
    end else if (wr_high) begin
      stg_div_d = write_high(stg_div_q, data);
    end
  end

  // Next-state, counters, tick generation and divisor commit at reload points.
  always_comb begin
    state_d   = state_q;
    act_div_d = act_div_q;
    cnt_d     = cnt_q;
    os_cnt_d  = os_cnt_q;
    rx_tick_d = 1'b0;
    tx_tick_d = 1'b0;
    commit    = 1'b0;
    case (state_q)
      IDLE: begin
        // Idle is a permanent reload point: keep cnt primed with the divisor
        // that will be active, committing any staged value right away.
        commit   = div_pending_q;
        cnt_d    = div_pending_q ? stg_div_q : act_div_q;
        os_cnt_d = '0;
        if (enable) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (!enable) begin
          // Abandon the period; a tick due on this edge is dropped.
          state_d  = IDLE;
          os_cnt_d = '0;
          cnt_d    = act_div_q;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - DIV_W'(1);
        end else begin
          rx_tick_d = 1'b1;
          tx_tick_d = (os_cnt_q == OS_LAST);
          os_cnt_d  = os_cnt_q + OS_W'(1);
          commit    = div_pending_q;
          cnt_d     = div_pending_q ? stg_div_q : act_div_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (commit) begin
      act_div_d = stg_div_q;
    end
    // A high-byte write that lands on a commit re-arms for the new value
    // while the previous staged value is the one being committed.
    if (wr_high) begin
      div_pending_d = 1'b1;
    end else if (commit) begin
      div_pending_d = 1'b0;
    end else begin
      div_pending_d = div_pending_q;
    end
  end

  // State register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      stg_div_q     <= RST_DIV;
      act_div_q     <= RST_DIV;
      cnt_q         <= RST_DIV;
      os_cnt_q      <= '0;
      rx_tick_q     <= 1'b0;
      tx_tick_q     <= 1'b0;
      div_pending_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      stg_div_q     <= stg_div_d;
      act_div_q     <= act_div_d;
      cnt_q         <= cnt_d;
      os_cnt_q      <= os_cnt_d;
      rx_tick_q     <= rx_tick_d;
      tx_tick_q     <= tx_tick_d;
      div_pending_q <= div_pending_d;
    end
  end

  assign rx_tick     = rx_tick_q;
  assign tx_tick     = tx_tick_q;
  assign div_pending = div_pending_q;

endmodule
